// File: rtl/entry_gate_controller_if.sv
// Signal bundle between the parking-lot entry barrier controller and its environment.
// fsm_state is a debug view of the controller state: 0 IDLE, 1 OPENING, 2 OPEN, 3 CLOSING.
interface entry_gate_controller_if #(
  parameter int CNT_W = 4
);
  // Handshake: req is a level sampled only while IDLE; grant or deny answers with
  // a one-cycle pulse the cycle after the sample; nothing is queued outside IDLE.
  logic             req;
  logic             sensorA;
  logic             sensorB;
  logic [CNT_W-1:0] car_count;
  logic             grant;
  logic             deny;
  logic             motor_open;
  logic             motor_close;
  logic             gate_up;
  logic             full;
  logic             timeout;
  logic [1:0]       fsm_state;

  modport master (
    output req, sensorA, sensorB, car_count,
    input  grant, deny, motor_open, motor_close, gate_up, full, timeout, fsm_state
  );

  modport slave (
    input  req, sensorA, sensorB, car_count,
    output grant, deny, motor_open, motor_close, gate_up, full, timeout, fsm_state
  );
endinterface

// File: rtl/entry_gate_controller.sv
// Entry barrier sequencer: grants requests below capacity, opens the gate, closes it
// once car_count moves, reverses on obstruction and times out an unused opening.
module entry_gate_controller #(
  parameter int CNT_W          = 4,
  parameter int CAPACITY       = 9,
  parameter int TRAVEL_CYCLES  = 25_000_000,
  parameter int TIMEOUT_CYCLES = 250_000_000,
  parameter int TMR_W          = 28
) (
  input logic                  clk,
  input logic                  reset,
  entry_gate_controller_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OPENING = 2'd1,
    OPEN    = 2'd2,
    CLOSING = 2'd3
  } state_t;

  localparam logic [TMR_W-1:0] TRAVEL_LAST  = TMR_W'(TRAVEL_CYCLES - 1);
  localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W:0]   CAP_V        = (CNT_W + 1)'(CAPACITY);

  state_t           state;
  logic [TMR_W-1:0] timer;
  logic [CNT_W-1:0] count_snap;
  logic             grant;
  logic             deny;
  logic             motor_open;
  logic             motor_close;
  logic             gate_up;
  logic             full;
  logic             timeout;

  logic cap_hit;
  logic entry_seen;
  logic obstructed;

  // Any difference from the snapshot counts, including a wrap such as 15 -> 0.
  assign cap_hit    = {1'b0, bus.car_count} >= CAP_V;
  assign entry_seen = (bus.car_count != count_snap) && !bus.sensorA && !bus.sensorB;
  assign obstructed = bus.sensorA || bus.sensorB;

  // Motor and gate_up are set alongside each transition, so they track the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      timer       <= '0;
      count_snap  <= '0;
      grant       <= 1'b0;
      deny        <= 1'b0;
      motor_open  <= 1'b0;
      motor_close <= 1'b0;
      gate_up     <= 1'b0;
      full        <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      full    <= cap_hit;
      grant   <= 1'b0;
      deny    <= 1'b0;
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          motor_open  <= 1'b0;
          motor_close <= 1'b0;
          gate_up     <= 1'b0;
          timer       <= '0;
          if (bus.req && !full) begin
            state      <= OPENING;
            count_snap <= bus.car_count;
            grant      <= 1'b1;
            motor_open <= 1'b1;
          end else if (bus.req) begin
            deny <= 1'b1;
          end
        end
        OPENING: begin
          if (timer == TRAVEL_LAST) begin
            state      <= OPEN;
            timer      <= '0;
            motor_open <= 1'b0;
            gate_up    <= 1'b1;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        OPEN: begin
          // Entry is checked first so it wins over a simultaneous timeout.
          if (entry_seen) begin
            state       <= CLOSING;
            timer       <= '0;
            gate_up     <= 1'b0;
            motor_close <= 1'b1;
          end else if (timer == TIMEOUT_LAST) begin
            state       <= CLOSING;
            timer       <= '0;
            gate_up     <= 1'b0;
            motor_close <= 1'b1;
            timeout     <= 1'b1;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        CLOSING: begin
          if (obstructed) begin
            state       <= OPENING;
            timer       <= '0;
            motor_close <= 1'b0;
            motor_open  <= 1'b1;
          end else if (timer == TRAVEL_LAST) begin
            state       <= IDLE;
            timer       <= '0;
            motor_close <= 1'b0;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        default: begin
          state       <= IDLE;
          timer       <= '0;
          motor_open  <= 1'b0;
          motor_close <= 1'b0;
          gate_up     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.grant       = grant;
  assign bus.deny        = deny;
  assign bus.motor_open  = motor_open;
  assign bus.motor_close = motor_close;
  assign bus.gate_up     = gate_up;
  assign bus.full        = full;
  assign bus.timeout     = timeout;
  assign bus.fsm_state   = state;
endmodule

// File: tb/tb_entry_gate_controller.sv
// Directed bench for entry_gate_controller with short strokes (travel 4, timeout 20).
module tb_entry_gate_controller;
  localparam int CNT_W   = 4;
  localparam int TRAVEL  = 4;
  localparam int TIMEOUT = 20;

  // Observation word: {fsm_state[1:0], grant, deny, motor_open, motor_close, gate_up, timeout, full}
  localparam logic [8:0] V_IDLE  = 9'b00_0000000;
  localparam logic [8:0] V_DENY  = 9'b00_0100001;
  localparam logic [8:0] V_GRANT = 9'b01_1010000;
  localparam logic [8:0] V_MO    = 9'b01_0010000;
  localparam logic [8:0] V_GU    = 9'b10_0000100;
  localparam logic [8:0] V_MC    = 9'b11_0001000;
  localparam logic [8:0] V_MC_TO = 9'b11_0001010;
  localparam logic [8:0] V_FULL  = 9'b00_0000001;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  entry_gate_controller_if #(.CNT_W(CNT_W)) bus ();

  entry_gate_controller #(
    .CNT_W(CNT_W),
    .CAPACITY(9),
    .TRAVEL_CYCLES(TRAVEL),
    .TIMEOUT_CYCLES(TIMEOUT),
    .TMR_W(28)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  logic [8:0] obs;
  assign obs = {bus.fsm_state, bus.grant, bus.deny, bus.motor_open, bus.motor_close,
                bus.gate_up, bus.timeout, bus.full};

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [8:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int n, input logic [8:0] v);
    repeat (n) exp_q.push_back(v);
  endtask

  task automatic drain(input string tag);
    logic [8:0] e;
    while (exp_q.size() > 0) begin
      step();
      e = exp_q.pop_front();
      chk(tag, 32'(obs), 32'(e));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset         = 1'b0;
    bus.req       = 1'b0;
    bus.sensorA   = 1'b0;
    bus.sensorB   = 1'b0;
    bus.car_count = 4'd3;
    repeat (2) step();
    chk("reset_state", 32'(obs), 32'(V_IDLE));
    reset = 1'b1;
    step();
    chk("idle_after_release", 32'(obs), 32'(V_IDLE));

    // 1: grant, 4-cycle open stroke, entry closes the gate
    bus.req = 1'b1;
    push(1, V_GRANT);
    drain("t1_grant");
    bus.req = 1'b0;
    push(3, V_MO); push(1, V_GU);
    drain("t1_open");
    bus.car_count = 4'd4;
    push(4, V_MC); push(1, V_IDLE);
    drain("t1_close");

    // 2: full lags car_count by one cycle, then each held req cycle is denied
    bus.car_count = 4'd9;
    chk("t2_full_lag", 32'(bus.full), 32'(0));
    step();
    chk("t2_full", 32'(bus.full), 32'(1));
    bus.req = 1'b1;
    push(3, V_DENY);
    drain("t2_deny");
    bus.req = 1'b0;
    push(2, V_IDLE | V_FULL);
    drain("t2_idle");

    // 3: no entry within 20 OPEN cycles -> timeout pulse with the close stroke
    bus.car_count = 4'd5;
    step();
    chk("t3_full_clear", 32'(bus.full), 32'(0));
    bus.req = 1'b1;
    push(1, V_GRANT);
    drain("t3_grant");
    bus.req = 1'b0;
    push(3, V_MO); push(TIMEOUT, V_GU); push(1, V_MC_TO); push(3, V_MC); push(1, V_IDLE);
    drain("t3_timeout");

    // 7: entry on the very cycle the timeout would fire -> close without timeout
    bus.req = 1'b1;
    push(1, V_GRANT);
    drain("t7_grant");
    bus.req = 1'b0;
    push(3, V_MO); push(TIMEOUT, V_GU);
    drain("t7_open");
    bus.car_count = 4'd6;
    push(4, V_MC); push(1, V_IDLE);
    drain("t7_tie");

    // 4: obstruction in closing cycle 2 reverses into a full open stroke
    bus.req = 1'b1;
    push(1, V_GRANT);
    drain("t4_grant");
    bus.req = 1'b0;
    push(3, V_MO); push(1, V_GU);
    drain("t4_open");
    bus.car_count = 4'd7;
    push(2, V_MC);
    drain("t4_close");
    bus.sensorB = 1'b1;
    push(1, V_MO);
    drain("t4_reverse");
    bus.sensorB = 1'b0;
    push(3, V_MO); push(1, V_GU); push(4, V_MC); push(1, V_IDLE);
    drain("t4_reclose");

    // 5: grant at 15 (full still lagging), then wrap to 0 counts as entry
    bus.car_count = 4'd15;
    bus.req       = 1'b1;
    push(1, V_GRANT | V_FULL);
    drain("t5_grant");
    bus.req = 1'b0;
    push(3, V_MO | V_FULL); push(1, V_GU | V_FULL);
    drain("t5_open");
    bus.car_count = 4'd0;
    push(4, V_MC); push(1, V_IDLE);
    drain("t5_wrap");

    // 6: asynchronous reset mid-opening, then immediate grant after release
    bus.req = 1'b1;
    push(1, V_GRANT);
    drain("t6_grant");
    bus.req = 1'b0;
    push(1, V_MO);
    drain("t6_opening");
    #2;
    reset = 1'b0;
    #1;
    chk("t6_async_reset", 32'(obs), 32'(V_IDLE));
    bus.req       = 1'b1;
    bus.car_count = 4'd0;
    #2;
    reset = 1'b1;
    step();
    chk("t6_regrant", 32'(obs), 32'(V_GRANT));
    bus.req = 1'b0;
    push(3, V_MO); push(1, V_GU);
    drain("t6_open");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
